// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the architectural PC and runs single-outstanding
// req/ack fetches. It presents fetched instructions to IF/ID and applies branch
// redirects, including redirects that arrive while a fetch is still on the bus.
module fetch_sequencer #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] PC_ADDR = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  stall,
  output logic                  fetch_req,
  output logic [ADDR_WIDTH-1:0] fetch_addr,
  input  logic                  fetch_ack,
  input  logic [DATA_WIDTH-1:0] fetch_data,
  output logic                  if_valid,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic [DATA_WIDTH-1:0] if_inst,
  output logic                  flush,
  output logic [31:0]           redirect_count
);

  localparam logic [DATA_WIDTH-1:0] NopInst = DATA_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {StIdle, StFetch, StDiscard, StHold} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  fetch_req_q, fetch_req_d;
  logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
  logic                  if_valid_q, if_valid_d;
  logic [ADDR_WIDTH-1:0] if_pc_q, if_pc_d;
  logic [DATA_WIDTH-1:0] if_inst_q, if_inst_d;
  logic                  flush_q, flush_d;
  logic [31:0]           redirect_count_q, redirect_count_d;

  logic [ADDR_WIDTH-1:0] target;
  logic                  unused_redirect_lsbs;

  // Redirect targets are word aligned; the low two bits are dropped.
  assign target               = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Next-state and next-output logic; every register holds unless a case updates it.
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    fetch_req_d      = fetch_req_q;
    fetch_addr_d     = fetch_addr_q;
    if_valid_d       = if_valid_q;
    if_pc_d          = if_pc_q;
    if_inst_d        = if_inst_q;
    // A redirect is accepted in every state.
    flush_d          = redirect_valid;
    redirect_count_d = redirect_count_q + {31'd0, redirect_valid};

    unique case (state_q)
      StIdle: begin
        fetch_req_d = 1'b1;
        state_d     = StFetch;
        if (redirect_valid) begin
          pc_d         = target;
          fetch_addr_d = target;
        end else begin
          fetch_addr_d = pc_q;
        end
      end
      StFetch: begin
        if (fetch_ack && !redirect_valid) begin
          if_inst_d   = fetch_data;
          if_pc_d     = fetch_addr_q;
          if_valid_d  = 1'b1;
          pc_d        = fetch_addr_q + ADDR_WIDTH'(4);
          fetch_req_d = 1'b0;
          state_d     = StHold;
        end else if (fetch_ack) begin
          pc_d        = target;
          fetch_req_d = 1'b0;
          state_d     = StIdle;
        end else if (redirect_valid) begin
          // The bus request cannot be withdrawn; wait for its ack and drop the data.
          pc_d    = target;
          state_d = StDiscard;
        end
      end
      StDiscard: begin
        if (redirect_valid) begin
          pc_d = target;
        end
        if (fetch_ack) begin
          fetch_req_d = 1'b0;
          state_d     = StIdle;
        end
      end
      StHold: begin
        if (redirect_valid) begin
          if_valid_d = 1'b0;
          pc_d       = target;
          state_d    = StIdle;
        end else if (!stall) begin
          if_valid_d   = 1'b0;
          fetch_req_d  = 1'b1;
          fetch_addr_d = pc_q;
          state_d      = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= StIdle;
      pc_q             <= PC_ADDR;
      fetch_req_q      <= 1'b0;
      fetch_addr_q     <= PC_ADDR;
      if_valid_q       <= 1'b0;
      if_pc_q          <= PC_ADDR;
      if_inst_q        <= NopInst;
      flush_q          <= 1'b0;
      redirect_count_q <= 32'd0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      fetch_req_q      <= fetch_req_d;
      fetch_addr_q     <= fetch_addr_d;
      if_valid_q       <= if_valid_d;
      if_pc_q          <= if_pc_d;
      if_inst_q        <= if_inst_d;
      flush_q          <= flush_d;
      redirect_count_q <= redirect_count_d;
    end
  end

  assign fetch_req      = fetch_req_q;
  assign fetch_addr     = fetch_addr_q;
  assign if_valid       = if_valid_q;
  assign if_pc          = if_pc_q;
  assign if_inst        = if_inst_q;
  assign flush          = flush_q;
  assign redirect_count = redirect_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer. Inputs are driven and outputs sampled at the
// falling edge, so every sample reflects the most recent rising edge.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall = 1'b0;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ack = 1'b0;
  logic [31:0] fetch_data = 32'h0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        flush;
  logic [31:0] redirect_count;

  int errors = 0;
  int checks = 0;

  fetch_sequencer #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .PC_ADDR   (32'h8000_0000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .stall         (stall),
    .fetch_req     (fetch_req),
    .fetch_addr    (fetch_addr),
    .fetch_ack     (fetch_ack),
    .fetch_data    (fetch_data),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_inst       (if_inst),
    .flush         (flush),
    .redirect_count(redirect_count)
  );

  always #5 clk = ~clk;

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    checks++; if (fetch_req !== 1'b0) begin errors++;
      $display("FAIL reset_req: got %b want 0", fetch_req); end
    checks++; if (fetch_addr !== 32'h8000_0000) begin errors++;
      $display("FAIL reset_addr: got %h want 80000000", fetch_addr); end
    checks++; if (if_valid !== 1'b0) begin errors++;
      $display("FAIL reset_valid: got %b want 0", if_valid); end
    checks++; if (if_pc !== 32'h8000_0000) begin errors++;
      $display("FAIL reset_if_pc: got %h want 80000000", if_pc); end
    checks++; if (if_inst !== 32'h0000_0013) begin errors++;
      $display("FAIL reset_inst: got %h want 00000013", if_inst); end
    checks++; if (flush !== 1'b0 || redirect_count !== 32'd0) begin errors++;
      $display("FAIL reset_flush_cnt: got %b/%0d want 0/0", flush, redirect_count); end
    reset = 1'b0;
  endtask

  // Three back-to-back fetches, each acked in the cycle the request is seen.
  task automatic test_boot;
    logic [31:0] data [3];
    data[0] = 32'h0000_0013;
    data[1] = 32'h0010_0093;
    data[2] = 32'h0020_0113;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (fetch_req !== 1'b1 || fetch_addr !== 32'h8000_0000 + 32'(4 * i)) begin
        errors++; $display("FAIL boot_req%0d: got %b/%h want 1/%h", i, fetch_req,
                           fetch_addr, 32'h8000_0000 + 32'(4 * i)); end
      fetch_ack  = 1'b1;
      fetch_data = data[i];
      @(negedge clk);
      fetch_ack = 1'b0;
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h8000_0000 + 32'(4 * i) ||
                    if_inst !== data[i] || fetch_req !== 1'b0) begin
        errors++; $display("FAIL boot_cap%0d: got v=%b pc=%h inst=%h req=%b", i,
                           if_valid, if_pc, if_inst, fetch_req); end
      checks++; if (flush !== 1'b0 || redirect_count !== 32'd0) begin errors++;
        $display("FAIL boot_flush%0d: got %b/%0d want 0/0", i, flush, redirect_count); end
    end
  endtask

  // Starts in HOLD; stray acks while holding must be ignored.
  task automatic test_stall;
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      fetch_ack  = 1'b1;
      fetch_data = 32'hFFFF_FFFF;
      @(negedge clk);
      checks++; if (if_valid !== 1'b1 || if_inst !== 32'h0020_0113 || fetch_req !== 1'b0)
      begin errors++; $display("FAIL stall_hold%0d: got v=%b inst=%h req=%b", i,
                               if_valid, if_inst, fetch_req); end
    end
    fetch_ack = 1'b0;
    stall     = 1'b0;
    @(negedge clk);
    checks++; if (fetch_req !== 1'b1 || fetch_addr !== 32'h8000_000C || if_valid !== 1'b0)
    begin errors++; $display("FAIL stall_release: got req=%b addr=%h v=%b want 1/8000000c/0",
                             fetch_req, fetch_addr, if_valid); end
  endtask

  task automatic test_redirect_in_flight;
    fetch_ack  = 1'b1;
    fetch_data = 32'h0030_0193;
    @(negedge clk);
    fetch_ack = 1'b0;
    @(negedge clk);
    checks++; if (fetch_req !== 1'b1 || fetch_addr !== 32'h8000_0010) begin errors++;
      $display("FAIL inflight_req: got %b/%h want 1/80000010", fetch_req, fetch_addr); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (flush !== 1'b1 || redirect_count !== 32'd1) begin errors++;
      $display("FAIL inflight_flush: got %b/%0d want 1/1", flush, redirect_count); end
    checks++; if (fetch_req !== 1'b1 || fetch_addr !== 32'h8000_0010) begin errors++;
      $display("FAIL inflight_hold_req: got %b/%h want 1/80000010", fetch_req, fetch_addr); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (flush !== 1'b0 || if_valid !== 1'b0 || fetch_req !== 1'b1) begin errors++;
        $display("FAIL inflight_wait%0d: got flush=%b v=%b req=%b", i, flush, if_valid,
                 fetch_req); end
    end
    fetch_ack  = 1'b1;
    fetch_data = 32'hBAD0_BAD0;
    @(negedge clk);
    fetch_ack = 1'b0;
    checks++; if (if_valid !== 1'b0 || fetch_req !== 1'b0) begin errors++;
      $display("FAIL inflight_drop: got v=%b req=%b want 0/0", if_valid, fetch_req); end
    @(negedge clk);
    checks++; if (fetch_req !== 1'b1 || fetch_addr !== 32'h8000_0100 ||
                  redirect_count !== 32'd1 || if_valid !== 1'b0) begin errors++;
      $display("FAIL inflight_target: got req=%b addr=%h cnt=%0d v=%b", fetch_req,
               fetch_addr, redirect_count, if_valid); end
  endtask

  task automatic test_redirect_with_ack;
    fetch_ack      = 1'b1;
    fetch_data     = 32'hBAD1_BAD1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    @(negedge clk);
    fetch_ack      = 1'b0;
    redirect_valid = 1'b0;
    checks++; if (if_valid !== 1'b0 || fetch_req !== 1'b0 || flush !== 1'b1 ||
                  redirect_count !== 32'd2) begin errors++;
      $display("FAIL ackredir_drop: got v=%b req=%b flush=%b cnt=%0d", if_valid,
               fetch_req, flush, redirect_count); end
    @(negedge clk);
    checks++; if (fetch_req !== 1'b1 || fetch_addr !== 32'h8000_0200 || flush !== 1'b0)
    begin errors++; $display("FAIL ackredir_target: got req=%b addr=%h flush=%b",
                             fetch_req, fetch_addr, flush); end
  endtask

  task automatic test_redirect_hold_stall;
    fetch_ack  = 1'b1;
    fetch_data = 32'h0040_0213;
    @(negedge clk);
    fetch_ack = 1'b0;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h8000_0200 || if_inst !== 32'h0040_0213)
    begin errors++; $display("FAIL holdredir_cap: got v=%b pc=%h inst=%h", if_valid,
                             if_pc, if_inst); end
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0300;
    @(negedge clk);
    stall          = 1'b0;
    redirect_valid = 1'b0;
    checks++; if (if_valid !== 1'b0 || flush !== 1'b1 || redirect_count !== 32'd3) begin
      errors++; $display("FAIL holdredir_drop: got v=%b flush=%b cnt=%0d want 0/1/3",
                         if_valid, flush, redirect_count); end
    @(negedge clk);
    checks++; if (fetch_req !== 1'b1 || fetch_addr !== 32'h8000_0300) begin errors++;
      $display("FAIL holdredir_target: got %b/%h want 1/80000300", fetch_req, fetch_addr); end
  endtask

  task automatic test_wrap;
    fetch_ack  = 1'b1;
    fetch_data = 32'h0000_0013;
    @(negedge clk);
    fetch_ack      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (redirect_count !== 32'd4) begin errors++;
      $display("FAIL wrap_cnt: got %0d want 4", redirect_count); end
    @(negedge clk);
    checks++; if (fetch_req !== 1'b1 || fetch_addr !== 32'hFFFF_FFFC) begin errors++;
      $display("FAIL wrap_align: got %b/%h want 1/fffffffc", fetch_req, fetch_addr); end
    fetch_ack  = 1'b1;
    fetch_data = 32'h0050_0293;
    @(negedge clk);
    fetch_ack = 1'b0;
    checks++; if (if_pc !== 32'hFFFF_FFFC || if_inst !== 32'h0050_0293) begin errors++;
      $display("FAIL wrap_cap: got pc=%h inst=%h want fffffffc/00500293", if_pc, if_inst); end
    @(negedge clk);
    checks++; if (fetch_req !== 1'b1 || fetch_addr !== 32'h0000_0000) begin errors++;
      $display("FAIL wrap_zero: got %b/%h want 1/00000000", fetch_req, fetch_addr); end
  endtask

  // Two redirects while a fetch is stuck on the bus; the later target must win.
  task automatic test_back_to_back;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0400;
    @(negedge clk);
    checks++; if (flush !== 1'b1 || redirect_count !== 32'd5) begin errors++;
      $display("FAIL b2b_first: got %b/%0d want 1/5", flush, redirect_count); end
    redirect_pc = 32'h8000_0500;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (flush !== 1'b1 || redirect_count !== 32'd6) begin errors++;
      $display("FAIL b2b_second: got %b/%0d want 1/6", flush, redirect_count); end
    fetch_ack  = 1'b1;
    fetch_data = 32'hBAD2_BAD2;
    @(negedge clk);
    fetch_ack = 1'b0;
    checks++; if (flush !== 1'b0 || fetch_req !== 1'b0 || if_valid !== 1'b0) begin errors++;
      $display("FAIL b2b_drop: got flush=%b req=%b v=%b", flush, fetch_req, if_valid); end
    @(negedge clk);
    checks++; if (fetch_req !== 1'b1 || fetch_addr !== 32'h8000_0500) begin errors++;
      $display("FAIL b2b_target: got %b/%h want 1/80000500", fetch_req, fetch_addr); end
  endtask

  task automatic test_reset_mid;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0600;
    @(negedge clk);
    redirect_valid = 1'b0;
    reset          = 1'b1;
    #1;
    checks++; if (fetch_req !== 1'b0 || fetch_addr !== 32'h8000_0000 || if_valid !== 1'b0 ||
                  if_pc !== 32'h8000_0000 || if_inst !== 32'h0000_0013) begin errors++;
      $display("FAIL rstmid_outs: got req=%b addr=%h v=%b pc=%h inst=%h", fetch_req,
               fetch_addr, if_valid, if_pc, if_inst); end
    checks++; if (flush !== 1'b0 || redirect_count !== 32'd0) begin errors++;
      $display("FAIL rstmid_cnt: got %b/%0d want 0/0", flush, redirect_count); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (fetch_req !== 1'b1 || fetch_addr !== 32'h8000_0000) begin errors++;
      $display("FAIL rstmid_boot: got %b/%h want 1/80000000", fetch_req, fetch_addr); end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_stall();
    test_redirect_in_flight();
    test_redirect_with_ack();
    test_redirect_hold_stall();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
